// File: rtl/qed_dup_scheduler.sv
// QED phase controller: alternates fetch between original and duplicate streams,
// counting both and pulsing qed_ready once a batch's duplicates match its originals.
module qed_dup_scheduler #(
   parameter int unsigned MAX_ORIG = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             stall_IF,
   input  logic             ifu_vld,
   input  logic             dup_trigger,
   input  logic             qic_vld,
   output logic             exec_dup,
   output logic [CNT_W-1:0] orig_cnt,
   output logic [CNT_W-1:0] dup_cnt,
   output logic             qed_ready,
   output logic             ovf_err
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ORIG);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ORIG  = 2'd1,
      DUP   = 2'd2,
      CHECK = 2'd3
   } state_t;

   state_t state;

   logic             fire_o_c;
   logic             fire_d_c;
   logic [CNT_W-1:0] orig_nxt_c;
   logic [CNT_W-1:0] dup_inc_c;
   logic             go_dup_c;

   assign fire_o_c   = ifu_vld & ~stall_IF;
   assign fire_d_c   = qic_vld & ~stall_IF;
   assign orig_nxt_c = (fire_o_c && (orig_cnt != MAX_CNT)) ? orig_cnt + ONE : orig_cnt;
   assign dup_inc_c  = dup_cnt + ONE;
   // A full i-cache forces the switch; a trigger only switches a non-empty batch.
   assign go_dup_c   = (orig_nxt_c == MAX_CNT) ||
                       (dup_trigger && !stall_IF && (orig_nxt_c != '0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         exec_dup  <= 1'b0;
         orig_cnt  <= '0;
         dup_cnt   <= '0;
         qed_ready <= 1'b0;
         ovf_err   <= 1'b0;
      end else begin
         qed_ready <= 1'b0;
         if (fire_o_c && (orig_cnt == MAX_CNT)) begin
            ovf_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               exec_dup <= 1'b0;
               orig_cnt <= '0;
               dup_cnt  <= '0;
               if (ena) begin
                  state <= ORIG;
               end
            end
            ORIG: begin
               // Losing ena mid-batch freezes counting and drains to DUP at the first unstalled cycle.
               if (!ena && (orig_cnt != '0)) begin
                  if (!stall_IF) begin
                     state    <= DUP;
                     exec_dup <= 1'b1;
                  end
               end else begin
                  orig_cnt <= orig_nxt_c;
                  if (go_dup_c) begin
                     state    <= DUP;
                     exec_dup <= 1'b1;
                  end else if (!ena && !fire_o_c) begin
                     state <= IDLE;
                  end
               end
            end
            DUP: begin
               if (fire_d_c) begin
                  dup_cnt <= dup_inc_c;
                  if (dup_inc_c == orig_cnt) begin
                     state     <= CHECK;
                     exec_dup  <= 1'b0;
                     qed_ready <= 1'b1;
                  end
               end
            end
            CHECK: begin
               exec_dup <= 1'b0;
               orig_cnt <= '0;
               dup_cnt  <= '0;
               state    <= ena ? ORIG : IDLE;
            end
            default: begin
               state    <= IDLE;
               exec_dup <= 1'b0;
            end
         endcase
      end
   end

endmodule
